// File: rtl/frame_err_injector.sv
// Line-side error injector. It corrupts payload beats by XOR with a programmable
// mask and has four modes: off, random, LFSR-triggered burst, and a one-shot hit
// at a programmed row/column. Each output beat is registered one cycle after its
// input beat. The module also counts the errors it has injected.

module frame_err_injector #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = 16'hB400,
  parameter int unsigned        PROT_COLS = 7,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_row_cnt,
  input  logic [10:0]       i_col_cnt,
  input  logic [DATA_W-1:0] i_frame_data,
  input  logic              i_frame_data_valid,
  input  logic              i_frame_data_fas,
  output logic [DATA_W-1:0] o_frame_data,
  output logic              o_frame_data_valid,
  output logic              o_frame_data_fas,
  output logic              o_err_inj,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_err_mask,
  input  logic [LFSR_W-1:0] i_thresh,
  input  logic [7:0]        i_burst_len,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_seed_load,
  input  logic [1:0]        i_shot_row,
  input  logic [10:0]       i_shot_col,
  input  logic              i_shot_arm,
  output logic              o_shot_busy,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RAND  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_SHOT  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  localparam logic [10:0]       PROT_LIM = 11'(PROT_COLS);
  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [7:0]        r_rem;
  logic [LFSR_W-1:0] r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_fas;
  logic              r_inj;

  logic              w_prot;
  logic              w_live;
  logic              w_trig;
  logic              w_shot_match;
  logic [1:0]        w_state_eff;
  logic [1:0]        w_state_d;
  logic [7:0]        w_rem_d;
  logic [7:0]        w_burst_m1;
  logic              w_hit;
  logic [LFSR_W-1:0] w_lfsr_step;

  // Row-0 overhead columns (FAS/ARQ) are never touched, even inside a burst.
  assign w_prot = i_frame_data_valid && (i_row_cnt == 2'd0) && (i_col_cnt < PROT_LIM);
  assign w_live = i_frame_data_valid && !w_prot;

  // Trigger uses the LFSR value before this beat's step; thresh 0 never fires.
  assign w_trig = w_live && (r_lfsr < i_thresh);

  assign w_shot_match = w_live && (i_row_cnt == i_shot_row) && (i_col_cnt == i_shot_col);

  // A mode change drops any burst/armed state so the current beat is judged
  // by the new mode starting from idle. Mode off also pins the FSM to idle.
  assign w_state_eff = ((i_mode != r_mode) || (i_mode == MODE_OFF)) ? ST_IDLE : r_state;

  assign w_burst_m1 = (i_burst_len == 8'd0) ? 8'd0 : (i_burst_len - 8'd1);

  // Galois right-shift step.
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);

  // Hit decision and FSM next state for the current beat.
  always_comb begin
    w_hit     = 1'b0;
    w_state_d = w_state_eff;
    w_rem_d   = r_rem;
    case (i_mode)
      MODE_RAND: begin
        w_hit     = w_trig;
        w_state_d = ST_IDLE;
      end
      MODE_BURST: begin
        if (w_state_eff == ST_BURST) begin
          // Inside a burst every live beat hits; triggers are ignored.
          if (w_live) begin
            w_hit   = 1'b1;
            w_rem_d = r_rem - 8'd1;
            if (r_rem <= 8'd1) begin
              w_state_d = ST_IDLE;
            end
          end
        end else if (w_trig) begin
          w_hit   = 1'b1;
          w_rem_d = w_burst_m1;
          // A one-beat burst is complete on the trigger beat itself.
          w_state_d = (w_burst_m1 != 8'd0) ? ST_BURST : ST_IDLE;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      MODE_SHOT: begin
        if (w_state_eff == ST_ARMED) begin
          // A protected target never matches, so the shot stays armed.
          if (w_shot_match) begin
            w_hit     = 1'b1;
            w_state_d = ST_IDLE;
          end
        end else if (i_shot_arm) begin
          w_state_d = ST_ARMED;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, remaining burst beats and last-seen mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= 8'd0;
      r_mode  <= MODE_OFF;
    end else begin
      r_state <= w_state_d;
      r_rem   <= w_rem_d;
      r_mode  <= i_mode;
    end
  end

  // LFSR: seed load beats stepping; it steps once per valid beat when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_ONE;
    end else if (i_seed_load) begin
      // An all-zero state would lock up the LFSR.
      r_lfsr <= (i_seed == '0) ? LFSR_ONE : i_seed;
    end else if ((i_mode != MODE_OFF) && i_frame_data_valid) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Saturating injected-error counter; a clear beats a simultaneous hit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Output beat register: the beat is delayed one cycle and XORed when it hits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fas   <= 1'b0;
      r_inj   <= 1'b0;
    end else begin
      r_data  <= i_frame_data ^ (w_hit ? i_err_mask : '0);
      r_valid <= i_frame_data_valid;
      r_fas   <= i_frame_data_fas;
      r_inj   <= w_hit;
    end
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;
  assign o_err_inj          = r_inj;
  assign o_shot_busy        = (r_state == ST_ARMED);
  assign o_err_cnt          = r_cnt;

endmodule

// File: tb/tb_frame_err_injector.sv
// Directed, self-checking bench for frame_err_injector. A second instance with a
// 4-bit counter shares all inputs and is used to check counter saturation.

module tb_frame_err_injector;

  logic        clk;
  logic        rst_n;
  logic [1:0]  row;
  logic [10:0] col;
  logic [7:0]  din;
  logic        vin;
  logic        fin;
  logic [1:0]  mode;
  logic [7:0]  mask;
  logic [15:0] thresh;
  logic [7:0]  blen;
  logic [15:0] seed;
  logic        seed_load;
  logic [1:0]  shot_row;
  logic [10:0] shot_col;
  logic        shot_arm;
  logic        cnt_clr;

  logic [7:0]  dout;
  logic        vout;
  logic        fout;
  logic        inj;
  logic        busy;
  logic [15:0] cnt;

  logic [7:0]  s_dout;
  logic        s_vout;
  logic        s_fout;
  logic        s_inj;
  logic        s_busy;
  logic [3:0]  s_cnt;

  int n_pass;
  int n_total;

  typedef struct {
    logic        v;
    logic [1:0]  row;
    logic [10:0] col;
    logic [7:0]  d;
    logic        fas;
    logic [7:0]  e_d;
    logic        e_inj;
  } vec_t;

  vec_t tbl [10];

  frame_err_injector u_dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_row_cnt          (row),
    .i_col_cnt          (col),
    .i_frame_data       (din),
    .i_frame_data_valid (vin),
    .i_frame_data_fas   (fin),
    .o_frame_data       (dout),
    .o_frame_data_valid (vout),
    .o_frame_data_fas   (fout),
    .o_err_inj          (inj),
    .i_mode             (mode),
    .i_err_mask         (mask),
    .i_thresh           (thresh),
    .i_burst_len        (blen),
    .i_seed             (seed),
    .i_seed_load        (seed_load),
    .i_shot_row         (shot_row),
    .i_shot_col         (shot_col),
    .i_shot_arm         (shot_arm),
    .o_shot_busy        (busy),
    .i_cnt_clr          (cnt_clr),
    .o_err_cnt          (cnt)
  );

  frame_err_injector #(.CNT_W(4)) u_sat (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_row_cnt          (row),
    .i_col_cnt          (col),
    .i_frame_data       (din),
    .i_frame_data_valid (vin),
    .i_frame_data_fas   (fin),
    .o_frame_data       (s_dout),
    .o_frame_data_valid (s_vout),
    .o_frame_data_fas   (s_fout),
    .o_err_inj          (s_inj),
    .i_mode             (mode),
    .i_err_mask         (mask),
    .i_thresh           (thresh),
    .i_burst_len        (blen),
    .i_seed             (seed),
    .i_seed_load        (seed_load),
    .i_shot_row         (shot_row),
    .i_shot_col         (shot_col),
    .i_shot_arm         (shot_arm),
    .o_shot_busy        (s_busy),
    .i_cnt_clr          (cnt_clr),
    .o_err_cnt          (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one beat, clock it, and leave outputs settled 1 time unit after the edge.
  task automatic beat(input logic v, input logic [1:0] r, input logic [10:0] c,
                      input logic [7:0] d, input logic f);
    vin = v;
    row = r;
    col = c;
    din = d;
    fin = f;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    shot_arm  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic idle();
    beat(1'b0, 2'd0, 11'd0, 8'h00, 1'b0);
  endtask

  task automatic bchk(input string nm, input logic v, input logic [1:0] r,
                      input logic [10:0] c, input logic [7:0] d,
                      input logic [7:0] ed, input logic ei);
    beat(v, r, c, d, 1'b0);
    chk({nm, "_data"}, 32'(dout), 32'(ed));
    chk({nm, "_inj"}, 32'(inj), 32'(ei));
  endtask

  initial begin
    logic [7:0]  rd;
    logic [10:0] rc;
    logic [1:0]  rr;
    logic        rv;
    logic        rf;

    // Mode 01, all-ones threshold, mask FF, seed 1: LFSR before each beat is
    // 1, B400, 5A00, 2D00, 1680, 0B40, 05A0, 02D0, (invalid: no step), 0168.
    tbl[0] = '{1'b1, 2'd0, 11'd0,  8'h00, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 2'd0, 11'd1,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 11'd2,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 2'd0, 11'd3,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 11'd4,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 2'd0, 11'd5,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 2'd0, 11'd6,  8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 2'd0, 11'd7,  8'h00, 1'b0, 8'hFF, 1'b1};
    tbl[8] = '{1'b0, 2'd1, 11'd2,  8'h5A, 1'b1, 8'h5A, 1'b0};
    tbl[9] = '{1'b1, 2'd1, 11'd3,  8'h12, 1'b0, 8'hED, 1'b1};

    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    row       = 2'd0;
    col       = 11'd0;
    din       = 8'h00;
    vin       = 1'b0;
    fin       = 1'b0;
    mode      = 2'b00;
    mask      = 8'hFF;
    thresh    = 16'hFFFF;
    blen      = 8'd4;
    seed      = 16'h0001;
    seed_load = 1'b0;
    shot_row  = 2'd0;
    shot_col  = 11'd0;
    shot_arm  = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state, with busy inputs around it.
    din = 8'hA5;
    vin = 1'b1;
    fin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(dout), 32'h0);
    chk("rst_valid", 32'(vout), 32'h0);
    chk("rst_fas", 32'(fout), 32'h0);
    chk("rst_inj", 32'(inj), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 00: pure 1-cycle delay with mask/threshold set to maximum.
    for (int i = 0; i < 1000; i++) begin
      rv = 1'($urandom);
      rf = 1'($urandom);
      rr = 2'($urandom);
      rc = 11'($urandom_range(0, 2047));
      rd = 8'($urandom);
      beat(rv, rr, rc, rd, rf);
      chk("m0_beat", {23'h0, vout, fout, inj, dout}, {23'h0, rv, rf, 1'b0, rd});
    end
    chk("m0_cnt", 32'(cnt), 32'h0);

    // Mode 01 table.
    mode      = 2'b01;
    thresh    = 16'hFFFF;
    mask      = 8'hFF;
    seed      = 16'h0001;
    seed_load = 1'b1;
    cnt_clr   = 1'b1;
    idle();
    for (int i = 0; i < 10; i++) begin
      beat(tbl[i].v, tbl[i].row, tbl[i].col, tbl[i].d, tbl[i].fas);
      chk($sformatf("m1_data%0d", i), 32'(dout), 32'(tbl[i].e_d));
      chk($sformatf("m1_inj%0d", i), 32'(inj), 32'(tbl[i].e_inj));
      chk($sformatf("m1_vf%0d", i), {30'h0, vout, fout}, {30'h0, tbl[i].v, tbl[i].fas});
    end
    chk("m1_cnt", 32'(cnt), 32'd2);

    // Mode 10: 4-beat burst over invalid gaps and a protected column.
    mode      = 2'b10;
    blen      = 8'd4;
    mask      = 8'h0F;
    thresh    = 16'hFFFF;
    seed_load = 1'b1;
    cnt_clr   = 1'b1;
    idle();
    bchk("b_trig", 1'b1, 2'd1, 11'd10, 8'h30, 8'h3F, 1'b1);
    thresh = 16'h0000;
    bchk("b_gap1", 1'b0, 2'd1, 11'd10, 8'h31, 8'h31, 1'b0);
    bchk("b_prot", 1'b1, 2'd0, 11'd2,  8'h32, 8'h32, 1'b0);
    bchk("b_hit2", 1'b1, 2'd1, 11'd11, 8'h33, 8'h3C, 1'b1);
    bchk("b_col7", 1'b1, 2'd0, 11'd7,  8'h34, 8'h3B, 1'b1);
    bchk("b_gap2", 1'b0, 2'd1, 11'd12, 8'h35, 8'h35, 1'b0);
    bchk("b_hit4", 1'b1, 2'd1, 11'd12, 8'h36, 8'h39, 1'b1);
    bchk("b_done", 1'b1, 2'd1, 11'd13, 8'h37, 8'h37, 1'b0);
    chk("b_cnt", 32'(cnt), 32'd4);

    // Burst length 0 behaves as 1.
    blen   = 8'd0;
    thresh = 16'hFFFF;
    bchk("b0_trig", 1'b1, 2'd1, 11'd20, 8'h00, 8'h0F, 1'b1);
    thresh = 16'h0000;
    bchk("b0_next", 1'b1, 2'd1, 11'd21, 8'h00, 8'h00, 1'b0);

    // Mode change mid-burst: the beat is judged by the new mode from idle.
    blen   = 8'd4;
    thresh = 16'hFFFF;
    bchk("mc_trig", 1'b1, 2'd1, 11'd30, 8'h00, 8'h0F, 1'b1);
    thresh = 16'h0000;
    bchk("mc_hit2", 1'b1, 2'd1, 11'd31, 8'h00, 8'h0F, 1'b1);
    mode = 2'b01;
    bchk("mc_new", 1'b1, 2'd1, 11'd32, 8'h00, 8'h00, 1'b0);
    mode = 2'b10;
    bchk("mc_back", 1'b1, 2'd1, 11'd33, 8'h00, 8'h00, 1'b0);
    chk("mc_cnt", 32'(cnt), 32'd7);

    // Reset in the middle of a burst.
    thresh = 16'hFFFF;
    bchk("rb_trig", 1'b1, 2'd1, 11'd40, 8'h00, 8'h0F, 1'b1);
    thresh = 16'h0000;
    bchk("rb_hit2", 1'b1, 2'd1, 11'd41, 8'h00, 8'h0F, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_async", {20'h0, vout, inj, dout, 2'b0}, 32'h0);
    chk("rb_async_cnt", 32'(cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rb_busy", 32'(busy), 32'h0);
    chk("rb_cnt0", 32'(cnt), 32'h0);
    // LFSR back at 1: thresh 2 fires once, then B400 does not.
    blen   = 8'd1;
    thresh = 16'h0002;
    bchk("rb_lfsr1", 1'b1, 2'd1, 11'd42, 8'h00, 8'h0F, 1'b1);
    bchk("rb_lfsr2", 1'b1, 2'd1, 11'd43, 8'h00, 8'h00, 1'b0);
    chk("rb_cnt1", 32'(cnt), 32'd1);

    // Counter saturation on the 4-bit instance.
    blen    = 8'd20;
    thresh  = 16'hFFFF;
    seed    = 16'h0001;
    seed_load = 1'b1;
    cnt_clr = 1'b1;
    idle();
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, 2'd1, 11'(100 + i), 8'h00, 1'b0);
      thresh = 16'h0000;
    end
    chk("sat_main", 32'(cnt), 32'd20);
    chk("sat_4bit", 32'(s_cnt), 32'd15);
    seed_load = 1'b1;
    idle();
    thresh  = 16'hFFFF;
    cnt_clr = 1'b1;
    beat(1'b1, 2'd1, 11'd200, 8'h00, 1'b0);
    chk("clr_hit", 32'(inj), 32'h1);
    chk("clr_main", 32'(cnt), 32'h0);
    chk("clr_4bit", 32'(s_cnt), 32'h0);

    // Seed 0 loads 1.
    mode      = 2'b01;
    seed      = 16'h0000;
    seed_load = 1'b1;
    thresh    = 16'h0002;
    mask      = 8'h3C;
    idle();
    bchk("seed0_a", 1'b1, 2'd1, 11'd5, 8'h00, 8'h3C, 1'b1);
    bchk("seed0_b", 1'b1, 2'd1, 11'd6, 8'h00, 8'h00, 1'b0);

    // Mode 11: one-shot at row 2, col 100.
    mode     = 2'b11;
    mask     = 8'hA5;
    shot_row = 2'd2;
    shot_col = 11'd100;
    cnt_clr  = 1'b1;
    idle();
    chk("s_busy0", 32'(busy), 32'h0);
    shot_arm = 1'b1;
    idle();
    chk("s_armed", 32'(busy), 32'h1);
    bchk("s_col99", 1'b1, 2'd2, 11'd99, 8'h00, 8'h00, 1'b0);
    bchk("s_inval", 1'b0, 2'd2, 11'd100, 8'h11, 8'h11, 1'b0);
    shot_arm = 1'b1;
    bchk("s_row1", 1'b1, 2'd1, 11'd100, 8'h22, 8'h22, 1'b0);
    chk("s_busy1", 32'(busy), 32'h1);
    bchk("s_fire", 1'b1, 2'd2, 11'd100, 8'h33, 8'h96, 1'b1);
    chk("s_busy_off", 32'(busy), 32'h0);
    bchk("s_again", 1'b1, 2'd2, 11'd100, 8'h44, 8'h44, 1'b0);
    chk("s_cnt", 32'(cnt), 32'd1);

    // Protected target never fires; a mode change clears busy.
    shot_row = 2'd0;
    shot_col = 11'd3;
    shot_arm = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) begin
      bchk("sp_prot", 1'b1, 2'd0, 11'd3, 8'h55, 8'h55, 1'b0);
    end
    chk("sp_busy", 32'(busy), 32'h1);
    mode   = 2'b01;
    thresh = 16'h0000;
    idle();
    chk("sp_mchg", 32'(busy), 32'h0);
    mode = 2'b11;
    idle();
    chk("sp_stay", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
